// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin sharing of one add/subtract datapath between
// nreq requesters. One operation is issued every two cycles. Each result is
// registered and tagged with the index of the requester that owns it.
`timescale 1ns/1ps

module addsub_arbiter #(
  parameter int dw   = 8,
  parameter int nreq = 4,
  parameter int idw  = (nreq > 1) ? $clog2(nreq) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [nreq-1:0]    req,
  input  logic [nreq*dw-1:0] dataa_i,
  input  logic [nreq*dw-1:0] datab_i,
  input  logic [nreq-1:0]    add_sub_i,
  output logic [nreq-1:0]    gnt,
  output logic [dw-1:0]      result_o,
  output logic               result_valid,
  output logic [idw-1:0]     result_id,
  output logic               busy
);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t         state;
  state_t         state_next;

  // Round-robin pointer: the requester that gets first look at the next arbitration
  logic [idw-1:0] ptr;
  logic [idw-1:0] ptr_next;

  // Winner of the current arbitration (only meaningful while any_req is set)
  logic           any_req;
  logic [idw-1:0] winner;
  logic [idw-1:0] probe;

  // The winner's operands, muxed out of the packed input buses
  logic [dw-1:0]  sel_a;
  logic [dw-1:0]  sel_b;
  logic           sel_add;
  logic [nreq-1:0] grant_vec;

  // Captured operation, owned by the granted requester for the CALC cycle
  logic [dw-1:0]  op_a;
  logic [dw-1:0]  op_b;
  logic           op_add;
  logic [idw-1:0] id_r;

  // Shared datapath output
  logic [dw-1:0]  calc;

  // Search upward from ptr, wrapping modulo nreq, for the first active request
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    probe   = '0;
    for (int k = 0; k < nreq; k++) begin
      if (int'(ptr) + k >= nreq)
        probe = idw'(int'(ptr) + k - nreq);
      else
        probe = idw'(int'(ptr) + k);
      if (!any_req && req[probe]) begin
        any_req = 1'b1;
        winner  = probe;
      end
    end
  end

  // Pick out the winner's operand slices and build its one-hot grant
  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    sel_add   = 1'b0;
    grant_vec = '0;
    for (int k = 0; k < nreq; k++) begin
      if (winner == idw'(k)) begin
        sel_a        = dataa_i[k*dw +: dw];
        sel_b        = datab_i[k*dw +: dw];
        sel_add      = add_sub_i[k];
        grant_vec[k] = any_req;
      end
    end
  end

  // Pointer moves to the requester just after the winner, wrapping to zero
  always_comb begin
    if (int'(winner) == nreq - 1)
      ptr_next = '0;
    else
      ptr_next = winner + idw'(1);
  end

  // Shared add/subtract unit, fed only from the captured operands (modulo 2^dw)
  always_comb begin
    if (op_add)
      calc = op_a + op_b;
    else
      calc = op_a - op_b;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next state: arbitrate in IDLE, spend exactly one cycle in CALC
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (any_req)
          state_next = CALC;
      end
      CALC: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Grant pulse, pointer update and operand capture at an IDLE arbitration edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt    <= '0;
      ptr    <= '0;
      id_r   <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_add <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          gnt <= grant_vec;
          if (any_req) begin
            ptr    <= ptr_next;
            id_r   <= winner;
            op_a   <= sel_a;
            op_b   <= sel_b;
            op_add <= sel_add;
          end
        end
        default: begin
          gnt <= '0;
        end
      endcase
    end
  end

  // Result register: loads at the edge ending CALC and holds until the next one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_o     <= '0;
      result_id    <= '0;
      result_valid <= 1'b0;
    end else begin
      if (state == CALC) begin
        result_o     <= calc;
        result_id    <= id_r;
        result_valid <= 1'b1;
      end else begin
        result_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == CALC);

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level round-robin / modulo-arithmetic model.
`timescale 1ns/1ps

module tb_addsub_arbiter;

  localparam int DW   = 8;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*DW-1:0]   dataa_i;
  logic [NREQ*DW-1:0]   datab_i;
  logic [NREQ-1:0]      add_sub_i;
  logic [NREQ-1:0]      gnt;
  logic [DW-1:0]        result_o;
  logic                 result_valid;
  logic [IDW-1:0]       result_id;
  logic                 busy;

  int n_cmp  = 0;
  int n_fail = 0;

  addsub_arbiter #(.dw(DW), .nreq(NREQ)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .dataa_i      (dataa_i),
    .datab_i      (datab_i),
    .add_sub_i    (add_sub_i),
    .gnt          (gnt),
    .result_o     (result_o),
    .result_valid (result_valid),
    .result_id    (result_id),
    .busy         (busy)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time limit so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected result of one operation, straight from modulo-2^DW arithmetic
  function automatic logic [DW-1:0] model_calc(input int a, input int b, input logic add);
    int r;
    if (add) r = (a + b) % 256;
    else     r = (a - b + 256) % 256;
    return DW'(r);
  endfunction

  // Round-robin choice: first requester at or after p, wrapping
  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input int a, input int b, input logic add);
    dataa_i[i*DW +: DW] = DW'(a);
    datab_i[i*DW +: DW] = DW'(b);
    add_sub_i[i]        = add;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    req       = '0;
    dataa_i   = '0;
    datab_i   = '0;
    add_sub_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp += 5;
      if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_gnt cyc%0d: got %b expected 0000", c, gnt); end
      if (result_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid cyc%0d: got %b expected 0", c, result_valid); end
      if (result_o !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_result cyc%0d: got %0d expected 0", c, result_o); end
      if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy cyc%0d: got %b expected 0", c, busy); end
      if (result_id !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_id cyc%0d: got %0d expected 0", c, result_id); end
    end
  endtask

  task automatic test_add_wrap();
    do_reset();
    set_ops(0, 200, 100, 1'b1);
    req = 4'b0001;
    tick();
    n_cmp += 2;
    if (gnt !== 4'b0001) begin n_fail++; $display("[TB] FAIL add_gnt: got %b expected 0001", gnt); end
    if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL add_busy: got %b expected 1", busy); end
    req = 4'b0000;
    tick();
    n_cmp += 4;
    if (result_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL add_valid: got %b expected 1", result_valid); end
    if (result_o !== 8'd44) begin n_fail++; $display("[TB] FAIL add_result: got %0d expected 44", result_o); end
    if (result_id !== 2'd0) begin n_fail++; $display("[TB] FAIL add_id: got %0d expected 0", result_id); end
    if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL add_gnt_drop: got %b expected 0000", gnt); end
    tick();
    n_cmp += 2;
    if (result_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL add_valid_drop: got %b expected 0", result_valid); end
    if (result_o !== 8'd44) begin n_fail++; $display("[TB] FAIL add_result_hold: got %0d expected 44", result_o); end
  endtask

  task automatic test_sub_underflow();
    int pulses;
    pulses = 0;
    set_ops(2, 5, 10, 1'b0);
    req = 4'b0100;
    tick();
    n_cmp += 1;
    if (gnt !== 4'b0100) begin n_fail++; $display("[TB] FAIL sub_gnt: got %b expected 0100", gnt); end
    req = 4'b0000;
    tick();
    if (result_valid === 1'b1) pulses++;
    n_cmp += 2;
    if (result_o !== 8'hFB) begin n_fail++; $display("[TB] FAIL sub_result: got %h expected fb", result_o); end
    if (result_id !== 2'd2) begin n_fail++; $display("[TB] FAIL sub_id: got %0d expected 2", result_id); end
    for (int c = 0; c < 5; c++) begin
      tick();
      if (result_valid === 1'b1) pulses++;
    end
    n_cmp += 1;
    if (pulses != 1) begin n_fail++; $display("[TB] FAIL sub_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_round_robin();
    int a[NREQ];
    int b[NREQ];
    logic add[NREQ];
    int who;
    logic [NREQ-1:0] exp_gnt;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      a[i]   = int'($urandom_range(0, 255));
      b[i]   = int'($urandom_range(0, 255));
      add[i] = 1'($urandom_range(0, 1));
      set_ops(i, a[i], b[i], add[i]);
    end
    req = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      tick();
      who = (c / 2) % NREQ;
      if (c % 2 == 0) begin
        exp_gnt      = '0;
        exp_gnt[who] = 1'b1;
        n_cmp += 1;
        if (gnt !== exp_gnt) begin n_fail++; $display("[TB] FAIL rr_gnt step%0d: got %b expected %b", c, gnt, exp_gnt); end
        req[who] = 1'b0;
      end else begin
        n_cmp += 4;
        if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL rr_gap step%0d: got %b expected 0000", c, gnt); end
        if (result_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL rr_valid step%0d: got %b expected 1", c, result_valid); end
        if (result_id !== IDW'(who)) begin n_fail++; $display("[TB] FAIL rr_id step%0d: got %0d expected %0d", c, result_id, who); end
        if (result_o !== model_calc(a[who], b[who], add[who])) begin
          n_fail++;
          $display("[TB] FAIL rr_result step%0d: got %0d expected %0d", c, result_o, model_calc(a[who], b[who], add[who]));
        end
        req[who] = 1'b1;
      end
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_fairness();
    do_reset();
    req = 4'b0010;
    tick();
    n_cmp += 1;
    if (gnt !== 4'b0010) begin n_fail++; $display("[TB] FAIL fair_first: got %b expected 0010", gnt); end
    req = 4'b0000;
    tick();
    req = 4'b1010;
    tick();
    n_cmp += 1;
    if (gnt !== 4'b1000) begin n_fail++; $display("[TB] FAIL fair_second: got %b expected 1000", gnt); end
    req = 4'b0010;
    tick();
    tick();
    n_cmp += 1;
    if (gnt !== 4'b0010) begin n_fail++; $display("[TB] FAIL fair_third: got %b expected 0010", gnt); end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_calc();
    // Pointer is at 2 after the fairness scenario (last grant went to 1)
    for (int i = 0; i < NREQ; i++) set_ops(i, 10 + i, 3, 1'b1);
    req = 4'b1111;
    tick();
    n_cmp += 2;
    if (gnt !== 4'b0100) begin n_fail++; $display("[TB] FAIL mid_gnt: got %b expected 0100", gnt); end
    if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_busy: got %b expected 1", busy); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp += 5;
    if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL async_gnt: got %b expected 0000", gnt); end
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL async_busy: got %b expected 0", busy); end
    if (result_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL async_valid: got %b expected 0", result_valid); end
    if (result_o !== 8'd0) begin n_fail++; $display("[TB] FAIL async_result: got %0d expected 0", result_o); end
    if (result_id !== 2'd0) begin n_fail++; $display("[TB] FAIL async_id: got %0d expected 0", result_id); end
    tick();
    n_cmp += 1;
    if (result_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL dropped_valid: got %b expected 0", result_valid); end
    @(negedge clk);
    reset = 1'b0;
    tick();
    n_cmp += 1;
    if (gnt !== 4'b0001) begin n_fail++; $display("[TB] FAIL post_reset_gnt: got %b expected 0001", gnt); end
    req = 4'b1110;
    tick();
    n_cmp += 3;
    if (result_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_valid: got %b expected 1", result_valid); end
    if (result_id !== 2'd0) begin n_fail++; $display("[TB] FAIL post_reset_id: got %0d expected 0", result_id); end
    if (result_o !== 8'd13) begin n_fail++; $display("[TB] FAIL post_reset_result: got %0d expected 13", result_o); end
    req = '0;
  endtask

  task automatic test_random();
    int m_ptr;
    int m_pending;
    int m_id;
    int w;
    logic [DW-1:0]      m_res;
    logic [DW-1:0]      hold_res;
    logic [IDW-1:0]     hold_id;
    logic [NREQ-1:0]    s_req;
    logic [NREQ*DW-1:0] s_a;
    logic [NREQ*DW-1:0] s_b;
    logic [NREQ-1:0]    s_add;
    logic [NREQ-1:0]    exp_gnt;
    logic               exp_valid;
    do_reset();
    m_ptr     = 0;
    m_pending = 0;
    m_id      = 0;
    m_res     = '0;
    hold_res  = '0;
    hold_id   = '0;
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 3) == 0) req = '0;
      else req = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++)
        set_ops(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      s_req = req;
      s_a   = dataa_i;
      s_b   = datab_i;
      s_add = add_sub_i;
      tick();
      exp_gnt   = '0;
      exp_valid = 1'b0;
      if (m_pending != 0) begin
        exp_valid = 1'b1;
        hold_res  = m_res;
        hold_id   = IDW'(m_id);
        m_pending = 0;
      end else if (s_req != '0) begin
        w          = rr_pick(s_req, m_ptr);
        exp_gnt[w] = 1'b1;
        m_res      = model_calc(int'(s_a[w*DW +: DW]), int'(s_b[w*DW +: DW]), s_add[w]);
        m_id       = w;
        m_ptr      = (w + 1) % NREQ;
        m_pending  = 1;
      end
      n_cmp += 5;
      if (gnt !== exp_gnt) begin n_fail++; $display("[TB] FAIL rand_gnt cyc%0d: got %b expected %b", c, gnt, exp_gnt); end
      if (result_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL rand_valid cyc%0d: got %b expected %b", c, result_valid, exp_valid); end
      if (result_o !== hold_res) begin n_fail++; $display("[TB] FAIL rand_result cyc%0d: got %0d expected %0d", c, result_o, hold_res); end
      if (result_id !== hold_id) begin n_fail++; $display("[TB] FAIL rand_id cyc%0d: got %0d expected %0d", c, result_id, hold_id); end
      if (busy !== (m_pending != 0)) begin n_fail++; $display("[TB] FAIL rand_busy cyc%0d: got %b expected %b", c, busy, (m_pending != 0)); end
    end
    req = '0;
  endtask

  // Scenario sequence
  initial begin
    reset     = 1'b1;
    req       = '0;
    dataa_i   = '0;
    datab_i   = '0;
    add_sub_i = '0;
    test_reset();
    test_add_wrap();
    test_sub_underflow();
    test_round_robin();
    test_fairness();
    test_reset_mid_calc();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
